// File: rtl/cycle_timer.sv
// cycle_timer: one-shot delay timer with ready/valid request and expiry handshakes,
// plus a free-running cycle counter that is snapshotted at the expiry edge.
module cycle_timer #(
    parameter int COUNT_WIDTH = 32,
    parameter int CYCLE_WIDTH = 64
) (
    input  logic                   clock,
    input  logic                   clear_n,
    input  logic                   request_valid,
    output logic                   request_ready,
    input  logic [COUNT_WIDTH-1:0] request_cycles,
    input  logic                   cancel,
    output logic                   expired_valid,
    input  logic                   expired_ready,
    output logic [CYCLE_WIDTH-1:0] expired_cycle,
    output logic [CYCLE_WIDTH-1:0] cycle_count,
    output logic                   busy
);

    // state    | meaning
    // IDLE     | waiting for a request; request_ready high once out of reset
    // COUNTING | remaining_q counts down toward the expiry edge
    // EXPIRED  | expiry and snapshot held until acknowledged
    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        COUNTING = 2'd1,
        EXPIRED  = 2'd2
    } state_t;

    state_t                 state_q;
    logic [COUNT_WIDTH-1:0] remaining_q;
    logic [COUNT_WIDTH-1:0] load_d;
    logic [CYCLE_WIDTH-1:0] cycle_q;
    logic [CYCLE_WIDTH-1:0] cycle_d;
    logic [CYCLE_WIDTH-1:0] exp_cycle_q;
    logic                   ready_q;
    logic                   valid_q;
    logic                   busy_q;

    assign cycle_d = cycle_q + CYCLE_WIDTH'(1);
    // A zero-cycle delay behaves as one cycle so expiry always follows acceptance.
    assign load_d  = (request_cycles == '0) ? COUNT_WIDTH'(1) : request_cycles;

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            cycle_q     <= '0;
            exp_cycle_q <= '0;
            ready_q     <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            cycle_q <= cycle_d;
            case (state_q)
                IDLE: begin
                    if (request_valid && ready_q) begin
                        remaining_q <= load_d;
                        state_q     <= COUNTING;
                        ready_q     <= 1'b0;
                        busy_q      <= 1'b1;
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                COUNTING: begin
                    // cancel takes priority even on the terminal-count edge
                    if (cancel) begin
                        remaining_q <= '0;
                        state_q     <= IDLE;
                        ready_q     <= 1'b1;
                        busy_q      <= 1'b0;
                    end else if (remaining_q == COUNT_WIDTH'(1)) begin
                        remaining_q <= '0;
                        state_q     <= EXPIRED;
                        valid_q     <= 1'b1;
                        exp_cycle_q <= cycle_d;
                    end else begin
                        remaining_q <= remaining_q - COUNT_WIDTH'(1);
                    end
                end
                EXPIRED: begin
                    if (expired_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= IDLE;
                    remaining_q <= '0;
                    valid_q     <= 1'b0;
                    ready_q     <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    assign request_ready = ready_q;
    assign expired_valid = valid_q;
    assign expired_cycle = exp_cycle_q;
    assign cycle_count   = cycle_q;
    assign busy          = busy_q;

endmodule
